// File: rtl/ntt_pkg.sv
// Shared defaults, FSM state encoding and bit-reversal helper for the NTT address controller.
package ntt_pkg;

  localparam int unsigned DEF_N      = 64;
  localparam int unsigned DEF_LOGN   = 6;
  localparam int unsigned DEF_BF_LAT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BREV  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ntt_state_t;

  // Reverses the low logn bits of v; upper bits come back zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int unsigned logn);
    logic [15:0] r;
    r = '0;
    for (int unsigned k = 0; k < 16; k++)
      if (k < logn) r[k] = v[logn-1-k];
    return r;
  endfunction

endpackage

// File: rtl/ntt_wr_pipe.sv
// Write-back delay line: carries the issue strobe and both addresses BF_LAT cycles.
module ntt_wr_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned BF_LAT = DEF_BF_LAT,
  parameter int unsigned AW     = DEF_LOGN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_en,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b
);

  logic [BF_LAT-1:0] en_sr;
  logic [AW-1:0]     a_sr [BF_LAT];
  logic [AW-1:0]     b_sr [BF_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sr <= '0;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        a_sr[i] <= '0;
        b_sr[i] <= '0;
      end
    end else begin
      en_sr[0] <= in_en;
      a_sr[0]  <= in_a;
      b_sr[0]  <= in_b;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        en_sr[i] <= en_sr[i-1];
        a_sr[i]  <= a_sr[i-1];
        b_sr[i]  <= b_sr[i-1];
      end
    end
  end

  assign out_en = en_sr[BF_LAT-1];
  assign out_a  = a_sr[BF_LAT-1];
  assign out_b  = b_sr[BF_LAT-1];

endmodule

// File: rtl/ntt_ctrl.sv
// NTT butterfly address/issue controller with BF_LAT-cycle write-back alignment.
// Optional bit-reversal permutation pass enabled by macro NTT_CTRL_BITREV_EN.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned LOGN   = DEF_LOGN,
  parameter int unsigned BF_LAT = DEF_BF_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic            swap,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [2:0]      stage,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  ntt_state_t      state;
  logic [LOGN-2:0] b;
  logic [CW-1:0]   cnt;
  logic [LOGN-1:0] bw, half, j, base;
  logic [LOGN-1:0] pipe_a, pipe_b;

`ifdef NTT_CTRL_BITREV_EN
  logic [LOGN:0]   bi, bnext;
  logic [LOGN-1:0] brev_b;
  logic            brev_ph;

  // Smallest k >= from with k < bitrev(k); returns N when none remain.
  function automatic logic [LOGN:0] first_swap(input logic [LOGN:0] from);
    logic [LOGN:0] r;
    r = (LOGN+1)'(N);
    for (int unsigned k = N; k > 0; k--)
      if (((LOGN+1)'(k-1) >= from) && (16'(k-1) < bitrev(16'(k-1), LOGN)))
        r = (LOGN+1)'(k-1);
    return r;
  endfunction

  assign bnext  = first_swap(bi + (LOGN+1)'(1));
  assign brev_b = LOGN'(bitrev(16'(bi), LOGN));
  assign swap   = (state == ST_BREV);
`else
  assign swap   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      stage <= '0;
      b     <= '0;
      cnt   <= '0;
`ifdef NTT_CTRL_BITREV_EN
      bi      <= '0;
      brev_ph <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE also samples start so a held start relaunches without an idle gap.
        ST_IDLE, ST_DONE: begin
          stage <= '0;
          b     <= '0;
          if (start) begin
`ifdef NTT_CTRL_BITREV_EN
            state   <= ST_BREV;
            bi      <= first_swap('0);
            brev_ph <= 1'b1;
`else
            state   <= ST_RUN;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
`ifdef NTT_CTRL_BITREV_EN
        ST_BREV: begin
          if (!hold || bi[LOGN]) begin
            if (bi[LOGN] || bnext[LOGN]) begin
              state <= ST_DRAIN;
              cnt   <= '0;
            end
            bi <= bnext;
          end
        end
`endif
        ST_RUN: begin
          if (!hold) begin
            if (b == (LOGN-1)'(N/2-1)) begin
              state <= ST_DRAIN;
              cnt   <= '0;
            end
            b <= b + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt == CW'(BF_LAT-1)) begin
`ifdef NTT_CTRL_BITREV_EN
            if (brev_ph) begin
              brev_ph <= 1'b0;
              state   <= ST_RUN;
            end else
`endif
            if (stage == 3'(LOGN-1)) begin
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
              stage <= stage + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bw        = {1'b0, b};
    half      = LOGN'(1) << stage;
    j         = bw & (half - LOGN'(1));
    base      = ((bw >> stage) << (stage + 3'd1)) | j;
    rd_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_idx    = '0;
    if (state == ST_RUN) begin
      rd_en     = !hold;
      rd_addr_a = base;
      rd_addr_b = base + half;
      tw_idx    = (LOGN-1)'(j << (3'(LOGN-1) - stage));
    end
`ifdef NTT_CTRL_BITREV_EN
    if (state == ST_BREV) begin
      rd_en     = !hold && !bi[LOGN];
      rd_addr_a = bi[LOGN-1:0];
      rd_addr_b = brev_b;
    end
`endif
  end

  // A swap writes each element to its partner's address.
  assign pipe_a = swap ? rd_addr_b : rd_addr_a;
  assign pipe_b = swap ? rd_addr_a : rd_addr_b;

  ntt_wr_pipe #(.BF_LAT(BF_LAT), .AW(LOGN)) u_wr_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_en  (rd_en),
    .in_a   (pipe_a),
    .in_b   (pipe_b),
    .out_en (wr_en),
    .out_a  (wr_addr_a),
    .out_b  (wr_addr_b)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed self-checking bench for ntt_ctrl at N=64, LOGN=6, BF_LAT=3.
module tb_ntt_ctrl;

  localparam int LOGN = 6;
  localparam int N    = 64;
  localparam int LAT  = 3;
  localparam int NB   = 192;
`ifdef NTT_CTRL_BITREV_EN
  localparam int PRE    = 31;
  localparam int NSW    = 28;
  localparam int NX_A   = 1;
  localparam int NX_B   = 32;
`else
  localparam int PRE    = 0;
  localparam int NSW    = 0;
  localparam int NX_A   = 0;
  localparam int NX_B   = 1;
`endif
  localparam int EXP_DONE = 210 + PRE;

  logic            clk, rst, start, hold;
  logic            rd_en, swap, wr_en, busy, done;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] tw_idx;
  logic [2:0]      stage;

  ntt_ctrl #(.N(N), .LOGN(LOGN), .BF_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .swap(swap), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int s; int b; int a; int bb; int tw;} vec_t;
  vec_t tbl[10];

  int n_chk = 0, n_fail = 0;
  int obs_a[NB], obs_b[NB], obs_tw[NB], obs_st[NB];
  int exp_we[512], exp_wa[512], exp_wb[512];
  int n_bf, n_sw, n_wr, done_k, first_k, pipe_err, hold_err, swap_err, wr_in_hold;
  int fs_a, fs_b, ls_a, ls_b;
  int nx_en, nx_a, nx_b, nx_st, nx_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int br6(input int v);
    int r = 0;
    for (int k = 0; k < LOGN; k++) if (v[k]) r |= 1 << (LOGN - 1 - k);
    return r;
  endfunction

  // Launches one transform; hold window [hf, hf+hl), extra start pulse at rp,
  // and optionally keeps start high over the tail to chain a second transform.
  task automatic run_xform(input int hf, input int hl, input int rp, input bit keep);
    bit seen = 1'b0;
    n_bf = 0; n_sw = 0; n_wr = 0; done_k = -1; first_k = -1;
    pipe_err = 0; hold_err = 0; swap_err = 0; wr_in_hold = 0;
    nx_en = 0; nx_a = -1; nx_b = -1; nx_st = -1; nx_done = -1;
    for (int i = 0; i < 512; i++) begin exp_we[i] = 0; exp_wa[i] = 0; exp_wb[i] = 0; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < EXP_DONE + 60; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        hold  = (k >= hf) && (k < hf + hl);
        start = (k == rp) || (keep && k >= EXP_DONE - 3);
      end
      #1;
      if (seen) begin
        nx_en = rd_en; nx_a = rd_addr_a; nx_b = rd_addr_b; nx_st = stage; nx_done = done;
        break;
      end
      if (rd_en) begin
        if (first_k < 0) first_k = k;
        if (swap) begin
          if (n_sw == 0) begin fs_a = rd_addr_a; fs_b = rd_addr_b; end
          ls_a = rd_addr_a; ls_b = rd_addr_b;
          if (tw_idx != 0) swap_err++;
          n_sw++;
        end else begin
          if (n_bf < NB) begin
            obs_a[n_bf] = rd_addr_a; obs_b[n_bf] = rd_addr_b;
            obs_tw[n_bf] = tw_idx;   obs_st[n_bf] = stage;
          end
          n_bf++;
        end
        exp_we[k+LAT] = 1;
        exp_wa[k+LAT] = swap ? rd_addr_b : rd_addr_a;
        exp_wb[k+LAT] = swap ? rd_addr_a : rd_addr_b;
      end
`ifndef NTT_CTRL_BITREV_EN
      if (swap) swap_err++;
`endif
      if (hold && rd_en) hold_err++;
      if (wr_en) n_wr++;
      if (hold && wr_en) wr_in_hold++;
      if (int'(wr_en) != exp_we[k] ||
          (wr_en && (int'(wr_addr_a) != exp_wa[k] || int'(wr_addr_b) != exp_wb[k])))
        pipe_err++;
      if (done) begin seen = 1'b1; done_k = k; end
    end
    start = 1'b0;
    hold  = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      int idx;
      idx = tbl[i].s * (N / 2) + tbl[i].b;
      chk($sformatf("%s_s%0d_b%0d_addr_a", tag, tbl[i].s, tbl[i].b), obs_a[idx], tbl[i].a);
      chk($sformatf("%s_s%0d_b%0d_addr_b", tag, tbl[i].s, tbl[i].b), obs_b[idx], tbl[i].bb);
      chk($sformatf("%s_s%0d_b%0d_tw", tag, tbl[i].s, tbl[i].b), obs_tw[idx], tbl[i].tw);
      chk($sformatf("%s_s%0d_b%0d_stage", tag, tbl[i].s, tbl[i].b), obs_st[idx], tbl[i].s);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, quiet, la, lb;
    tbl[0] = '{0,  0,  0,  1,  0};
    tbl[1] = '{0,  5, 10, 11,  0};
    tbl[2] = '{1,  3,  5,  7, 16};
    tbl[3] = '{2,  6, 10, 14, 16};
    tbl[4] = '{2, 31, 59, 63, 24};
    tbl[5] = '{3,  9, 17, 25,  4};
    tbl[6] = '{4, 13, 13, 29, 26};
    tbl[7] = '{4, 20, 36, 52,  8};
    tbl[8] = '{5,  0,  0, 32,  0};
    tbl[9] = '{5, 31, 31, 63, 31};

    rst = 1'b0; start = 1'b0; hold = 1'b0;
    #12;
    chk("reset_rd_en", rd_en, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stage", stage, 0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Plain transform.
    run_xform(-100, 0, -1, 1'b0);
    chk("run1_done_cycle", done_k, EXP_DONE);
    chk("run1_first_rd_k", first_k, 0);
    chk("run1_bf_issues", n_bf, NB);
    chk("run1_wr_count", n_wr, NB + NSW);
    chk("run1_pipe_align", pipe_err, 0);
    chk("run1_done_width", nx_done, 0);
    chk("run1_swap_bad", swap_err, 0);
    check_table("run1");
`ifdef NTT_CTRL_BITREV_EN
    la = 0; lb = 0;
    for (int i = 0; i < N; i++) if (i < br6(i)) begin la = i; lb = br6(i); end
    chk("brev_ops", n_sw, NSW);
    chk("brev_first_a", fs_a, 1);
    chk("brev_first_b", fs_b, 32);
    chk("brev_last_a", ls_a, la);
    chk("brev_last_b", ls_b, lb);
`endif

    // Hold mid stage 2, ignored start re-pulse, then start held into DONE.
    run_xform(80 + PRE, 5, 50 + PRE, 1'b1);
    chk("run2_done_cycle", done_k, EXP_DONE + 5);
    chk("run2_hold_rd", hold_err, 0);
    chk("run2_wr_in_hold", wr_in_hold, 3);
    chk("run2_bf_issues", n_bf, NB);
    chk("run2_pipe_align", pipe_err, 0);
    check_table("run2");
    chk("chain_rd_en", nx_en, 1);
    chk("chain_addr_a", nx_a, NX_A);
    chk("chain_addr_b", nx_b, NX_B);
    chk("chain_stage", nx_st, 0);

    // Asynchronous reset during stage 4 of the chained transform.
    for (w = 0; w < 400 && stage != 3'd4; w++) begin @(posedge clk); #2; end
    chk("reach_stage4", stage, 4);
    #2 rst = 1'b0;
    #1;
    chk("abort_rd_en", rd_en, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stage", stage, 0);
    chk("abort_addrs", int'(|{rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b}), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    quiet = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (wr_en || done || busy) quiet++;
    end
    chk("post_abort_quiet", quiet, 0);

    // Fresh transform after the abort.
    @(posedge clk); #1;
    run_xform(-100, 0, -1, 1'b0);
    chk("run3_done_cycle", done_k, EXP_DONE);
    chk("run3_bf_issues", n_bf, NB);
    chk("run3_first_stage", obs_st[0], 0);
    chk("run3_first_a", obs_a[0], 0);
    chk("run3_first_b", obs_b[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
